// File: rtl/sobel_pkg.sv
// Shared constants and encodings for the Sobel frame writer and its border sequencer.
package sobel_pkg;

  localparam int N_DEFAULT  = 64;
  localparam int AW_DEFAULT = 12;
  localparam int MW_DEFAULT = 11;
  localparam int PIX_W      = 8;
  localparam int SAT_MAX    = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    BORDER = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Border walk: top row, bottom row, then left/right pairs for each inner row.
  typedef enum logic [1:0] {
    PH_TOP   = 2'd0,
    PH_BOT   = 2'd1,
    PH_LEFT  = 2'd2,
    PH_RIGHT = 2'd3
  } brd_phase_t;

endpackage

// File: rtl/sobel_border_addr.sv
// Border address sequencer: walks the 4N-4 frame-edge addresses with adders only.
module sobel_border_addr
  import sobel_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [AW-1:0] TOP_END   = AW'(N - 1);
  localparam logic [AW-1:0] BOT_BASE  = AW'(N * (N - 1));
  localparam logic [AW-1:0] BOT_END   = AW'(N * N - 1);
  localparam logic [AW-1:0] SIDE_BASE = AW'(N);
  localparam logic [AW-1:0] ROW_SPAN  = AW'(N - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - N - 1);
  localparam logic [AW-1:0] ONE       = AW'(1);

  brd_phase_t    phase_q;
  logic [AW-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      phase_q <= PH_TOP;
      addr_q  <= '0;
    end else if (step) begin
      unique case (phase_q)
        PH_TOP: begin
          if (addr_q == TOP_END) begin
            phase_q <= PH_BOT;
            addr_q  <= BOT_BASE;
          end else begin
            addr_q  <= addr_q + ONE;
          end
        end
        PH_BOT: begin
          if (addr_q == BOT_END) begin
            phase_q <= PH_LEFT;
            addr_q  <= SIDE_BASE;
          end else begin
            addr_q  <= addr_q + ONE;
          end
        end
        // Left edge i*N jumps to right edge i*N+N-1; right edge +1 lands on the next row's left edge.
        PH_LEFT: begin
          phase_q <= PH_RIGHT;
          addr_q  <= addr_q + ROW_SPAN;
        end
        PH_RIGHT: begin
          phase_q <= PH_LEFT;
          addr_q  <= addr_q + ONE;
        end
        default: begin
          phase_q <= PH_TOP;
          addr_q  <= '0;
        end
      endcase
    end
  end

  assign addr = addr_q;
  assign last = (phase_q == PH_RIGHT) && (addr_q == LAST_ADDR);

endmodule

// File: rtl/sobel_frame_writer.sv
// Writes saturated Sobel magnitudes for interior pixels in raster order, then zero-fills
// the border and pulses done.
module sobel_frame_writer
  import sobel_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int AW = AW_DEFAULT,
  parameter int MW = MW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [MW-1:0]    in_data,
  output logic             in_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] N_A     = AW'(N);
  localparam logic [AW-1:0] IDX_MIN = AW'(1);
  localparam logic [AW-1:0] IDX_MAX = AW'(N - 2);

  function automatic logic [PIX_W-1:0] sat_pix(input logic [MW-1:0] v);
    if (v > MW'(SAT_MAX)) return PIX_W'(SAT_MAX);
    return v[PIX_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [AW-1:0]    row_q, col_q;
  logic [AW-1:0]    int_addr;
  logic             xfer, last_int;
  logic             brd_start, brd_step, brd_last, brd_drain_q;
  logic [AW-1:0]    brd_addr;
  logic             wr_en_p1;
  logic [AW-1:0]    wr_addr_p1;
  logic [PIX_W-1:0] wr_data_p1;

  assign in_ready = (state_q == STREAM);
  assign xfer     = in_valid && in_ready;
  assign last_int = (row_q == IDX_MAX) && (col_q == IDX_MAX);
  assign int_addr = row_q * N_A + col_q;

  sobel_border_addr #(
    .N  (N),
    .AW (AW)
  ) u_border (
    .clk   (clk),
    .rst   (rst),
    .start (brd_start),
    .step  (brd_step),
    .addr  (brd_addr),
    .last  (brd_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    brd_start = 1'b0;
    brd_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          brd_start = 1'b1;
        end
      end
      STREAM: begin
        busy = 1'b1;
        if (xfer && last_int) state_d = BORDER;
      end
      // The drain cycle lets the final border write reach the output before done.
      BORDER: begin
        busy = 1'b1;
        if (brd_drain_q) state_d = FINISH;
        else             brd_step = 1'b1;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p1: registered write port, one cycle after acceptance or border step
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      brd_drain_q <= 1'b0;
      wr_en_p1    <= 1'b0;
      wr_addr_p1  <= '0;
      wr_data_p1  <= '0;
    end else begin
      wr_en_p1 <= 1'b0;
      if (state_q == IDLE && start) begin
        row_q       <= IDX_MIN;
        col_q       <= IDX_MIN;
        brd_drain_q <= 1'b0;
      end
      if (xfer) begin
        wr_en_p1   <= 1'b1;
        wr_addr_p1 <= int_addr;
        wr_data_p1 <= sat_pix(in_data);
        if (col_q == IDX_MAX) begin
          col_q <= IDX_MIN;
          row_q <= row_q + IDX_MIN;
        end else begin
          col_q <= col_q + IDX_MIN;
        end
      end
      if (brd_step) begin
        wr_en_p1   <= 1'b1;
        wr_addr_p1 <= brd_addr;
        wr_data_p1 <= '0;
        if (brd_last) brd_drain_q <= 1'b1;
      end
    end
  end

  assign wr_en   = wr_en_p1;
  assign wr_addr = wr_addr_p1;
  assign wr_data = wr_data_p1;

endmodule

// File: doc/sobel_frame_writer.md
Name: sobel_frame_writer

Overview:
- Write-side counterpart of the Sobel window-address reader.
- Accepts the stream of Sobel gradient magnitudes, one per interior pixel, in row-major raster order.
- Saturates each magnitude to 8 bits and writes it into the output frame memory at its row-major address.
- Fills the image border with zeros, then reports frame completion; sits between the Sobel datapath and the ROM_OUT-style frame buffer.

Parameters:
- N, 64, image width and height in pixels (square image, N >= 3).
- AW, 12, frame memory address width; must satisfy 2**AW >= N*N.
- MW, 11, width of the incoming gradient magnitude (|Gx|+|Gy| max 2040).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- in_valid  input  1  in_data holds a valid magnitude.
- in_data  input  MW  unsigned gradient magnitude for the next interior pixel.
- in_ready  output  1  block accepts in_data this cycle.
- wr_en  output  1  frame memory write strobe.
- wr_addr  output  AW  row-major write address, i*N+j.
- wr_data  output  8  pixel value to write.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset: state=IDLE. in_ready, wr_en, busy and done are 0; wr_addr and wr_data are 0; row/col counters are cleared. Reset mid-frame abandons the frame with no further writes.
- States:
  - IDLE -> STREAM when start=1.
  - STREAM -> BORDER on acceptance of the last interior pixel.
  - BORDER -> FINISH after the last border write.
  - FINISH -> IDLE unconditionally.
- start outside IDLE is ignored. start and rst together: rst wins.
- STREAM:
  - in_ready=1 (combinational from state). Transfer occurs when in_valid && in_ready.
  - Interior counters: row i and col j each run 1..N-2, with j fastest. Wrap j=N-2 -> j=1, i+1.
  - Each transfer produces a registered write one cycle later:
    - wr_en=1
    - wr_addr = i*N+j (computed at full AW width, no truncation for legal N)
    - wr_data = in_data > 255 ? 255 : in_data[7:0]
  - Cycles with in_valid=0 produce wr_en=0 and do not advance the counters.
  - Total interior transfers: (N-2)^2.
- BORDER: in_ready=0. One zero write per cycle (wr_data=0, wr_en=1), 4N-4 consecutive cycles, in this order:
  - top row, addresses 0..N-1;
  - bottom row, addresses N*(N-1)..N*N-1;
  - then for i=1..N-2: i*N followed by i*N+N-1.
- The first border write occurs two cycles after the last interior acceptance, so there is one bubble cycle carrying the final interior write.
- busy: 1 from the cycle after start is sampled through the last border write; 0 in IDLE and FINISH.
- done: 1 for exactly one cycle, in FINISH, the cycle after the last border write. wr_en=0 in that cycle.
- Latency: one cycle from interior acceptance to write.
- Reference timing for N=64 with continuous valid, start sampled at cycle 0:
  - acceptances at cycles 1..3844;
  - interior writes at cycles 2..3845;
  - border writes at cycles 3846..4097;
  - done at cycle 4098.
- Every address 0..N*N-1 is written exactly once per frame.

Decomposition:
- sobel_pkg holds:
  - image size constant N_DEFAULT=64;
  - AW and MW defaults;
  - pixel width 8 and saturation max 255;
  - state encoding IDLE/STREAM/BORDER/FINISH.
- One sub-module: sobel_border_addr. It is a counter/sequencer producing the 4N-4 border addresses in the order above, with start, step and last outputs.
- The saturation clamp stays inline.

Test Plan:
- Reset check: assert rst for 3 cycles mid-activity, then check in_ready=0, wr_en=0, busy=0, done=0, wr_addr=0, wr_data=0.
- Full frame, N=64, in_data=11'd100 with valid held high:
  - 3844 writes starting at addresses 65, 66, ..., 126, 129, ...; last interior address 4030; all data 100.
  - 252 zero writes starting 0..63, then 4032..4095.
  - done pulse at cycle 4098; scoreboard confirms 4096 unique addresses.
- Saturation: in_data 0, 255, 256, 2040 -> wr_data 0, 255, 255, 255.
- Backpressure: in_valid pattern 1,0,0,1,1,0 -> exactly 3 writes at addresses 65, 66, 67, each one cycle after its acceptance; no write on idle cycles.
- Control: start pulsed during STREAM is ignored and the address sequence is unchanged. rst mid-STREAM, then a new start, restarts at address 65.
- Parameter N=4:
  - interior writes at 5, 6, 9, 10;
  - border writes at 0, 1, 2, 3, 12, 13, 14, 15, 4, 7, 8, 11;
  - done pulse the cycle after the final write to address 11.
